sram_controller: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_wait_counter.sv | 31 +++
 rtl/sram_controller.sv | 154 +++++++++++++++
 tb/tb_sram_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Sequencing states and the halfword-select encoding live here.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int   SRAM_DW   = 16;
    localparam logic HALF_LOW  = 1'b0;
    localparam logic HALF_HIGH = 1'b1;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half wait counter: counts 0..WAIT_CYCLES-1 and wraps,
// flagging the final cycle of a half access on o_last.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    // One bit minimum so a single-cycle wait still has a legal vector.
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign o_last = (r_cnt == TERM);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM accesses
// (low half, then high half) and stalls the pipeline via ready meanwhile.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam logic [31:0] BASE = BASE_ADDR;

    state_t r_state, w_state_nxt;

    logic               r_is_wr;
    logic [SRAM_AW-2:0] r_word;
    logic [31:0]        r_wdata;
    logic [SRAM_DW-1:0] r_lo;
    logic [31:0]        r_rdata;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [SRAM_DW-1:0] r_dq_out;
    logic               r_oe;
    logic               r_we_n;

    logic               w_req;
    logic               w_latch;
    logic               w_last;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic [31:0]        w_offset;
    logic [SRAM_AW-2:0] w_word_in;
    logic               w_is_wr_nxt;
    logic [SRAM_AW-2:0] w_word_nxt;
    logic [31:0]        w_wdata_nxt;
    logic               w_busy_nxt;
    logic               w_unused_bits;

    // Unsigned wrap below BASE falls out of the 32-bit subtraction.
    assign w_offset      = address - BASE;
    assign w_word_in     = w_offset[SRAM_AW:2];
    assign w_unused_bits = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

    assign w_req   = rd_en | wr_en;
    assign w_latch = (r_state == IDLE) && w_req;

    assign w_is_wr_nxt = w_latch ? wr_en      : r_is_wr;
    assign w_word_nxt  = w_latch ? w_word_in  : r_word;
    assign w_wdata_nxt = w_latch ? write_data : r_wdata;

    assign w_cnt_clr = (r_state == IDLE) || (r_state == DONE);
    assign w_cnt_en  = (r_state == LOW)  || (r_state == HIGH);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_last (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        unique case (r_state)
            IDLE: begin
                ready = ~w_req;
                if (w_req) w_state_nxt = LOW;
            end
            LOW: begin
                if (w_last) w_state_nxt = HIGH;
            end
            HIGH: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                ready       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == LOW) || (w_state_nxt == HIGH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_is_wr <= 1'b0;
            r_word  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_is_wr <= w_is_wr_nxt;
            r_word  <= w_word_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // Pin registers are loaded from the next state so they are valid
    // for every cycle of LOW and HIGH, including the first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_oe        <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            r_oe   <= w_busy_nxt && w_is_wr_nxt;
            r_we_n <= ~(w_busy_nxt && w_is_wr_nxt);
            if (w_state_nxt == LOW) begin
                r_sram_addr <= {w_word_nxt, HALF_LOW};
                if (w_is_wr_nxt) r_dq_out <= w_wdata_nxt[15:0];
            end else if (w_state_nxt == HIGH) begin
                r_sram_addr <= {w_word_nxt, HALF_HIGH};
                if (w_is_wr_nxt) r_dq_out <= w_wdata_nxt[31:16];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo    <= '0;
            r_rdata <= '0;
        end else if (!r_is_wr && w_last) begin
            if (r_state == LOW)  r_lo    <= sram_dq_in;
            if (r_state == HIGH) r_rdata <= {sram_dq_in, r_lo};
        end
    end

    assign read_data   = r_rdata;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_oe;
    assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_controller.sv
// Directed and randomized bench for sram_controller against a
// halfword-array reference of the SRAM and the last loaded word.
module tb_sram_controller;

    localparam int W  = 2;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en, wr_en;
    logic [31:0]   address, write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;
    logic          sram_dq_oe, sram_we_n;

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // Pin-level SRAM: a write commits at the end of each cycle with we_n low.
    logic [15:0] mem [0:(1<<AW)-1];
    assign sram_dq_in = mem[sram_addr];
    always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;

    logic [15:0] ref_mem [int];
    logic [31:0] ref_rd;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Halfword index: ((addr - base) / 4 mod 2^17) * 2 + half.
    function automatic int hidx(input logic [31:0] a, input int half);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'(((off >> 2) % 32'h20000) * 2) + half;
    endfunction

    // op: 0 load, 1 store, 2 both enables (store). Entered at a negedge in
    // IDLE, or in DONE when b2b is set; leaves at the DONE negedge.
    task automatic access(input int op, input logic [31:0] a, input logic [31:0] d,
                          input bit b2b, input bit scramble);
        int lowc, wec, oec, addr_bad, k, lo, hi;
        bit is_wr, done;
        logic [AW-1:0] ea;
        is_wr = (op != 0);
        lo = hidx(a, 0);
        hi = hidx(a, 1);
        rd_en = (op != 1); wr_en = (op != 0); address = a; write_data = d;
        if (b2b) @(negedge clk);
        #1;
        chk("idle_req_ready", {31'd0, ready}, 32'd0);
        lowc = 1; wec = 0; oec = 0; addr_bad = 0; k = 0; done = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (scramble && n == 0) begin
                rd_en = 1'($urandom); wr_en = 1'($urandom);
                address = $urandom; write_data = $urandom;
            end
            #1;
            if (ready) begin done = 1; break; end
            lowc++; k++;
            ea = (k <= W) ? AW'(lo) : AW'(hi);
            if (sram_addr !== ea) addr_bad++;
            if (!sram_we_n) wec++;
            if (sram_dq_oe) oec++;
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
        chk("stall_cycles", lowc, 1 + 2*W);
        chk("addr_sequence_errs", addr_bad, 0);
        chk("we_low_cycles", wec, is_wr ? 2*W : 0);
        chk("oe_high_cycles", oec, is_wr ? 2*W : 0);
        if (is_wr) begin
            ref_mem[lo] = d[15:0];
            ref_mem[hi] = d[31:16];
        end else begin
            ref_rd = {ref_mem[hi], ref_mem[lo]};
        end
        chk("read_data", read_data, ref_rd);
        chk("sram_word", {mem[hi], mem[lo]}, {ref_mem[hi], ref_mem[lo]});
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk); #1;
        chk("idle_ready", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] v, old_hi;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        ref_rd = '0;
        for (int i = 0; i < 64; i++) begin
            v = 16'($urandom); mem[i] <= v; ref_mem[i] = v;
            v = 16'($urandom); mem[(1<<AW)-64+i] <= v; ref_mem[(1<<AW)-64+i] = v;
        end
        mem[2] <= 16'h5678; ref_mem[2] = 16'h5678;
        mem[3] <= 16'h1234; ref_mem[3] = 16'h1234;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        rst = 1'b0;
        idle_cycle();

        access(1, 32'd1024, 32'hDEADBEEF, 0, 0);
        chk("store_w0", {16'd0, mem[0]}, 32'h0000BEEF);
        chk("store_w1", {16'd0, mem[1]}, 32'h0000DEAD);
        idle_cycle();
        access(0, 32'd1028, 32'h0, 0, 0);
        chk("load_1028", read_data, 32'h12345678);
        idle_cycle();
        access(2, 32'd1032, 32'hA5A50F0F, 0, 0);
        chk("both_w4", {16'd0, mem[4]}, 32'h00000F0F);
        chk("both_w5", {16'd0, mem[5]}, 32'h0000A5A5);
        chk("both_rd_kept", read_data, 32'h12345678);
        idle_cycle();
        access(0, 32'd1024, 32'h0, 0, 1);
        chk("b2b_load", read_data, 32'hDEADBEEF);
        access(1, 32'd1036, 32'hCAFEF00D, 1, 0);
        chk("b2b_store", {mem[7], mem[6]}, 32'hCAFEF00D);
        idle_cycle();
        access(1, 32'd1020, 32'h13572468, 0, 0);
        chk("wrap_hi", {mem[18'h3FFFF], mem[18'h3FFFE]}, 32'h13572468);
        access(0, 32'd1020, 32'h0, 1, 0);
        idle_cycle();

        // Reset while the high half of a store is being driven.
        old_hi = ref_mem[hidx(32'd1040, 1)];
        wr_en = 1'b1; address = 32'd1040; write_data = 32'h11223344;
        @(negedge clk); wr_en = 1'b0;
        repeat (W) @(negedge clk);
        #1;
        chk("pre_rst_addr", {14'd0, sram_addr}, 32'(hidx(32'd1040, 1)));
        chk("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("abort_read_data", read_data, 32'd0);
        ref_rd = '0;
        ref_mem[hidx(32'd1040, 0)] = 16'h3344;
        @(negedge clk); rst = 1'b0;
        idle_cycle();
        access(0, 32'd1040, 32'h0, 0, 0);
        chk("abort_old_hi", {16'd0, read_data[31:16]}, {16'd0, old_hi});

        for (int t = 0; t < 40; t++) begin
            int op;
            bit b2b;
            logic [31:0] a;
            op  = $urandom_range(0, 2);
            b2b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 32'd1024 - 32'(4 * $urandom_range(1, 8));
            else                           a = 32'd1024 + 32'(4 * $urandom_range(0, 15));
            a = a + 32'($urandom_range(0, 3));
            if (!b2b) idle_cycle();
            access(op, a, $urandom, b2b, 1'($urandom_range(0, 1)));
        end
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
